// File: rtl/sdram_port_arbiter.sv
// Shares the two bank ports of the dual-bank SDRAM controller among NREQ requesters.
// Define SDRAM_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sdram_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_DEPTH = 23
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sd_rdy,
  input  logic                           sd_sync,
  output logic                           sd_en0,
  output logic                           sd_en1,
  output logic                           sd_rw0,
  output logic                           sd_rw1,
  output logic [ADDR_DEPTH-1:0]          sd_addr0,
  output logic [ADDR_DEPTH-1:0]          sd_addr1,
  output logic [7:0]                     sd_data_wr0,
  output logic [7:0]                     sd_data_wr1,
  input  logic [7:0]                     sd_data_rd0,
  input  logic [7:0]                     sd_data_rd1,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0]                req_rw,
  input  logic [NREQ*(ADDR_DEPTH+1)-1:0] req_addr,
  input  logic [NREQ*8-1:0]              req_wdata,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [NREQ*8-1:0]              rsp_rdata
);
  localparam int IW = $clog2(NREQ);
  localparam int AW = ADDR_DEPTH + 1;

  logic [1:0]                       slot_v, slot_rw;
  logic [1:0][IW-1:0]               slot_id;
  logic [1:0][ADDR_DEPTH-1:0]       slot_addr;
  logic [1:0][7:0]                  slot_wdata;
  logic [1:0]                       pend_v, pend_rw;
  logic [1:0][IW-1:0]               pend_id;
  logic [1:0][NREQ-1:0]             cand;
  logic [1:0]                       grant_v;
  logic [1:0][IW-1:0]               grant_id;
  logic [1:0][7:0]                  rd_bus;
  logic [NREQ-1:0]                  rsp_valid_d;
  logic [NREQ*8-1:0]                rsp_rdata_d;
`ifdef SDRAM_ARB_STRICT_PRIO_EN
`else
  logic [1:0][IW-1:0]               rr_ptr, rr_nxt;
`endif

  assign rd_bus = {sd_data_rd1, sd_data_rd0};

  // Per-bank arbitration; a requester only ever targets one bank, so the two
  // grants never collide on req_ready.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    for (int b = 0; b < 2; b++) begin
      cand[b]     = '0;
      grant_v[b]  = 1'b0;
      grant_id[b] = '0;
      for (int i = 0; i < NREQ; i++)
        cand[b][i] = req_valid[i] && (req_addr[i*AW + ADDR_DEPTH] == (b == 1));
`ifdef SDRAM_ARB_STRICT_PRIO_EN
      for (int i = NREQ-1; i >= 0; i--)
        if (cand[b][i]) begin
          grant_v[b]  = 1'b1;
          grant_id[b] = IW'(i);
        end
`else
      // Descending scan so the candidate closest to rr_ptr is assigned last.
      for (int k = NREQ-1; k >= 0; k--) begin
        idx = int'(rr_ptr[b]) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (cand[b][idx]) begin
          grant_v[b]  = 1'b1;
          grant_id[b] = IW'(idx);
        end
      end
      rr_nxt[b] = (int'(grant_id[b]) == NREQ-1) ? '0 : grant_id[b] + 1'b1;
`endif
      grant_v[b] = grant_v[b] && !slot_v[b] && !rst;
      if (grant_v[b]) req_ready[grant_id[b]] = 1'b1;
    end
  end

  // Both banks may complete to one requester; their data is merged.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    for (int b = 0; b < 2; b++)
      if (sd_sync && pend_v[b]) begin
        rsp_valid_d[pend_id[b]] = 1'b1;
        if (pend_rw[b]) rsp_rdata_d[int'(pend_id[b])*8 +: 8] = rsp_rdata_d[int'(pend_id[b])*8 +: 8] | rd_bus[b];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v     <= '0;
      slot_rw    <= '0;
      slot_id    <= '0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      pend_v     <= '0;
      pend_rw    <= '0;
      pend_id    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
`ifdef SDRAM_ARB_STRICT_PRIO_EN
`else
      rr_ptr     <= '0;
`endif
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sd_sync && sd_rdy && slot_v[b]) begin
          slot_v[b]  <= 1'b0;
          pend_v[b]  <= 1'b1;
          pend_id[b] <= slot_id[b];
          pend_rw[b] <= slot_rw[b];
        end else begin
          if (sd_sync && pend_v[b]) pend_v[b] <= 1'b0;
          if (grant_v[b]) begin
            slot_v[b]     <= 1'b1;
            slot_id[b]    <= grant_id[b];
            slot_rw[b]    <= req_rw[grant_id[b]];
            slot_addr[b]  <= req_addr[int'(grant_id[b])*AW +: ADDR_DEPTH];
            slot_wdata[b] <= req_wdata[int'(grant_id[b])*8 +: 8];
`ifdef SDRAM_ARB_STRICT_PRIO_EN
`else
            rr_ptr[b]     <= rr_nxt[b];
`endif
          end
        end
      end
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  assign sd_en0      = slot_v[0];
  assign sd_en1      = slot_v[1];
  assign sd_rw0      = slot_rw[0];
  assign sd_rw1      = slot_rw[1];
  assign sd_addr0    = slot_addr[0];
  assign sd_addr1    = slot_addr[1];
  assign sd_data_wr0 = slot_wdata[0];
  assign sd_data_wr1 = slot_wdata[1];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: sync every 8 cycles, hand-computed expectations.
module tb_sdram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AD   = 23;
  localparam int AW   = AD + 1;

  logic clk = 1'b0;
  logic rst, sd_rdy, sd_sync;
  logic sd_en0, sd_en1, sd_rw0, sd_rw1;
  logic [AD-1:0] sd_addr0, sd_addr1;
  logic [7:0] sd_data_wr0, sd_data_wr1, sd_data_rd0, sd_data_rd1;
  logic [NREQ-1:0] req_valid, req_ready, req_rw, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata, rsp_rdata;

  sdram_port_arbiter #(.NREQ(NREQ), .ADDR_DEPTH(AD)) dut (
    .clk(clk), .rst(rst), .sd_rdy(sd_rdy), .sd_sync(sd_sync),
    .sd_en0(sd_en0), .sd_en1(sd_en1), .sd_rw0(sd_rw0), .sd_rw1(sd_rw1),
    .sd_addr0(sd_addr0), .sd_addr1(sd_addr1),
    .sd_data_wr0(sd_data_wr0), .sd_data_wr1(sd_data_wr1),
    .sd_data_rd0(sd_data_rd0), .sd_data_rd1(sd_data_rd1),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int phase = 0;
  logic [NREQ-1:0] outst;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the controller model raises sd_sync once per 8-cycle frame.
  task automatic step();
    @(posedge clk);
    #1;
    phase   = (phase + 1) % 8;
    sd_sync = (phase == 0);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic rw, input logic bank,
                         input logic [AD-1:0] a, input logic [7:0] d);
    req_valid[i]         = v;
    req_rw[i]            = rw;
    req_addr[i*AW +: AW] = {bank, a};
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic wait_sync();
    int n = 0;
    while (!sd_sync && n < 20) begin
      step();
      n++;
    end
    if (!sd_sync) chk("sync_timeout", 64'(sd_sync), 64'd1);
  endtask

  // One outstanding request per requester, from accept to rsp_valid.
  initial begin
    outst = '0;
    forever begin
      @(negedge clk);
      if (rst) outst = '0;
      else
        for (int i = 0; i < NREQ; i++) begin
          if (rsp_valid[i]) outst[i] = 1'b0;
          if (req_ready[i]) begin
            chk($sformatf("one_outstanding_%0d", i), 64'(outst[i]), 64'd0);
            outst[i] = 1'b1;
          end
        end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic flag;
    int n, cyc, s;
    int ord[5];
    int gc[5];
    int exp_ord[5];
    logic [NREQ-1:0] expw[3];
    exp_ord = '{0, 1, 2, 3, 0};
`ifdef SDRAM_ARB_STRICT_PRIO_EN
    expw = '{4'b0001, 4'b0001, 4'b0001};
`else
    expw = '{4'b0001, 4'b1000, 4'b0001};
`endif
    rst = 1'b1; sd_rdy = 1'b1; sd_sync = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    sd_data_rd0 = 8'hA5; sd_data_rd1 = 8'h3C;
    repeat (3) step();
    chk("rst_en", 64'({sd_en1, sd_en0}), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    step();

    // Single read
    set_req(0, 1, 1, 0, 23'h000123, 8'h00); #1;
    chk("t1_ready", 64'(req_ready), 64'b0001);
    step();
    set_req(0, 0, 0, 0, 23'h0, 8'h0);
    chk("t1_slot_en", 64'(sd_en0), 64'd1);
    wait_sync();
    chk("t1_issue_en", 64'(sd_en0), 64'd1);
    chk("t1_issue_addr", 64'(sd_addr0), 64'h123);
    chk("t1_issue_rw", 64'(sd_rw0), 64'd1);
    flag = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) chk("t1_slot_freed", 64'(sd_en0), 64'd0);
      flag = flag | (|rsp_valid);
    end
    step();
    chk("t1_early_rsp", 64'(flag), 64'd0);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("t1_rsp_rdata", 64'(rsp_rdata[7:0]), 64'hA5);

    // Round-robin on bank 1
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 1, AD'(i), 8'h0);
    #1;
    n = 0; cyc = 0; flag = 1'b0;
    while (n < 5 && cyc < 80) begin
      flag = flag | sd_en0;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) ord[n] = i;
        gc[n] = cyc;
        n++;
      end
      step();
      cyc++;
    end
    req_valid = '0;
    chk("rr_grants", 64'(n), 64'd5);
    for (int g = 0; g < 5; g++) chk($sformatf("rr_order_%0d", g), 64'(ord[g]), 64'(exp_ord[g]));
    for (int g = 1; g < 4; g++) chk($sformatf("rr_frame_gap_%0d", g), 64'(gc[g+1] - gc[g]), 64'd8);
    chk("rr_bank0_idle", 64'(flag), 64'd0);
    repeat (24) step();

    // Dual bank
    set_req(1, 1, 0, 0, 23'h000456, 8'h5A);
    set_req(2, 1, 1, 1, 23'h000789, 8'h00); #1;
    chk("dual_ready", 64'(req_ready), 64'b0110);
    step();
    req_valid = '0;
    wait_sync();
    chk("dual_en", 64'({sd_en1, sd_en0}), 64'b11);
    chk("dual_wr0", 64'({sd_rw0, sd_data_wr0}), 64'h05A);
    chk("dual_rd1", 64'({sd_rw1, sd_addr1}), 64'({1'b1, 23'h000789}));
    repeat (9) step();
    chk("dual_rsp_valid", 64'(rsp_valid), 64'b0110);
    chk("dual_rdata1", 64'(rsp_rdata[15:8]), 64'h00);
    chk("dual_rdata2", 64'(rsp_rdata[23:16]), 64'h3C);
    repeat (4) step();

    // Controller not ready
    sd_rdy = 1'b0;
    set_req(0, 1, 0, 0, 23'h000777, 8'h11); #1;
    chk("nr_ready0", 64'(req_ready), 64'b0001);
    step();
    req_valid[0] = 1'b0;
    set_req(3, 1, 1, 0, 23'h0000AA, 8'h00); #1;
    s = 0; cyc = 0; flag = 1'b0;
    while (s < 3 && cyc < 40) begin
      flag = flag | req_ready[3] | (|rsp_valid);
      if (sd_sync) s++;
      step();
      cyc++;
    end
    chk("nr_syncs", 64'(s), 64'd3);
    chk("nr_no_grant", 64'(flag), 64'd0);
    chk("nr_slot_hold", 64'({sd_en0, sd_rw0, sd_addr0, sd_data_wr0}), 64'({1'b1, 1'b0, 23'h000777, 8'h11}));
    sd_rdy = 1'b1;
    wait_sync();
    chk("nr_issue_en", 64'(sd_en0), 64'd1);
    chk("nr_full_no_ready", 64'(req_ready[3]), 64'd0);
    step();
    chk("nr_freed", 64'(sd_en0), 64'd0);
    chk("nr_regrant", 64'(req_ready), 64'b1000);
    step();
    req_valid[3] = 1'b0;
    chk("nr_next_slot", 64'({sd_en0, sd_addr0}), 64'({1'b1, 23'h0000AA}));
    repeat (7) step();
    chk("nr_wr_rsp", 64'(rsp_valid), 64'b0001);
    chk("nr_wr_rdata", 64'(rsp_rdata[7:0]), 64'h00);
    repeat (12) step();

    // Reset mid-flight
    set_req(0, 1, 1, 0, 23'h000321, 8'h00); #1;
    step();
    req_valid[0] = 1'b0;
    wait_sync();
    step();
    step();
    rst = 1'b1;
    set_req(1, 1, 1, 1, 23'h000001, 8'h00); #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    flag = 1'b0;
    repeat (3) begin
      step();
      flag = flag | (|{sd_en0, sd_en1, sd_rw0, sd_rw1, sd_addr0, sd_addr1, sd_data_wr0,
                       sd_data_wr1, rsp_valid, rsp_rdata, req_ready});
    end
    chk("mid_rst_outputs", 64'(flag), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      step();
      flag = flag | (|rsp_valid);
    end
    chk("mid_rst_no_rsp", 64'(flag), 64'd0);

    // Contention for bank 0 between requesters 0 and 3
    for (int r = 0; r < 3; r++) begin
      set_req(0, 1, 1, 0, 23'h000010, 8'h00);
      set_req(3, 1, 1, 0, 23'h000030, 8'h00); #1;
      chk($sformatf("prio_round_%0d", r), 64'(req_ready), 64'(expw[r]));
      step();
      req_valid = '0;
      cyc = 0;
      while (rsp_valid == '0 && cyc < 30) begin
        step();
        cyc++;
      end
      chk($sformatf("prio_rsp_%0d", r), 64'(rsp_valid), 64'(expw[r]));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
